// File: rtl/multi_cycle_controller_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multi_cycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       ZERO;
    logic       mem_ready;
    logic       pc_ld;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       jal_reg;
    logic       pc_to_reg;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_cntrl;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, func, ZERO, mem_ready,
        output pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_write,
               reg_dst, jal_reg, pc_to_reg, mem_to_reg, alu_src_a, alu_src_b,
               alu_cntrl, pc_src, instr_done, illegal, state
    );

    modport slave (
        output opcode, func, ZERO, mem_ready,
        input  pc_ld, i_or_d, mem_read, mem_write, ir_write, reg_write,
               reg_dst, jal_reg, pc_to_reg, mem_to_reg, alu_src_a, alu_src_b,
               alu_cntrl, pc_src, instr_done, illegal, state
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM: decodes IR fields and sequences a shared
// instruction/data memory datapath with an optional ready handshake.
module multi_cycle_controller #(
    parameter int unsigned MEM_HANDSHAKE = 1
) (
    input logic                      clk,
    input logic                      rst,
    multi_cycle_controller_if.master bus
);
    localparam logic [3:0] ST_IF = 4'd0, ST_ID = 4'd1, ST_MEM_ADDR = 4'd2,
        ST_MEM_RD = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WR = 4'd5, ST_R_EX = 4'd6,
        ST_R_WB = 4'd7, ST_I_EX = 4'd8, ST_I_WB = 4'd9, ST_BEQ = 4'd10,
        ST_JMP = 4'd11, ST_JAL = 4'd12, ST_JR = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011,
        OP_SW = 6'b101011, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010,
        OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010,
        FN_AND = 6'b100100, FN_OR = 6'b100101, FN_SLT = 6'b101010,
        FN_JR = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110,
        ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_SLT = 3'b111;

    logic [3:0] state_q, state_d;
    logic       mem_rdy, is_rfunc, id_ok;

    logic       mem_read_c, mem_write_c, ir_write_c, reg_write_c;
    logic       pc_write_c, pc_write_cond_c;
    logic       reg_dst_c, jal_reg_c, pc_to_reg_c, mem_to_reg_c;
    logic       i_or_d_c, alu_src_a_c, instr_done_c, illegal_c;
    logic [1:0] alu_src_b_c, pc_src_c;
    logic [2:0] alu_cntrl_c;

    assign mem_rdy  = (MEM_HANDSHAKE == 0) ? 1'b1 : bus.mem_ready;
    assign is_rfunc = (bus.func == FN_ADD) || (bus.func == FN_SUB) ||
                      (bus.func == FN_AND) || (bus.func == FN_OR)  ||
                      (bus.func == FN_SLT);
    assign id_ok    = (bus.opcode == OP_LW)   || (bus.opcode == OP_SW)   ||
                      (bus.opcode == OP_ADDI) || (bus.opcode == OP_SLTI) ||
                      (bus.opcode == OP_BEQ)  || (bus.opcode == OP_J)    ||
                      (bus.opcode == OP_JAL)  ||
                      ((bus.opcode == OP_RTYPE) && (is_rfunc || (bus.func == FN_JR)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IF;
        else     state_q <= state_d;
    end

    // Next-state decode; undecodable instructions and spare codes fall back to IF
    always_comb begin
        state_d = ST_IF;
        case (state_q)
            ST_IF:       state_d = mem_rdy ? ST_ID : ST_IF;
            ST_ID: begin
                case (bus.opcode)
                    OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
                    OP_ADDI, OP_SLTI: state_d = ST_I_EX;
                    OP_BEQ:           state_d = ST_BEQ;
                    OP_J:             state_d = ST_JMP;
                    OP_JAL:           state_d = ST_JAL;
                    OP_RTYPE: begin
                        if (bus.func == FN_JR) state_d = ST_JR;
                        else if (is_rfunc)     state_d = ST_R_EX;
                        else                   state_d = ST_IF;
                    end
                    default:          state_d = ST_IF;
                endcase
            end
            ST_MEM_ADDR: state_d = (bus.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_d = mem_rdy ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR:   state_d = mem_rdy ? ST_IF : ST_MEM_WR;
            ST_R_EX:     state_d = ST_R_WB;
            ST_I_EX:     state_d = ST_I_WB;
            default:     state_d = ST_IF;
        endcase
    end

    always_comb begin
        mem_read_c = 1'b0;  mem_write_c = 1'b0;  ir_write_c = 1'b0;
        reg_write_c = 1'b0; pc_write_c = 1'b0;   pc_write_cond_c = 1'b0;
        reg_dst_c = 1'b0;   jal_reg_c = 1'b0;    pc_to_reg_c = 1'b0;
        mem_to_reg_c = 1'b0; i_or_d_c = 1'b0;    alu_src_a_c = 1'b0;
        instr_done_c = 1'b0; illegal_c = 1'b0;
        alu_src_b_c = 2'b00; pc_src_c = 2'b00;   alu_cntrl_c = ALU_ADD;
        case (state_q)
            ST_IF: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = mem_rdy;
                pc_write_c  = mem_rdy;
            end
            ST_ID: begin
                alu_src_b_c  = 2'b11;
                illegal_c    = ~id_ok;
                instr_done_c = ~id_ok;
            end
            ST_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            ST_MEM_RD: begin
                i_or_d_c   = 1'b1;
                mem_read_c = 1'b1;
            end
            ST_MEM_WB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            ST_MEM_WR: begin
                i_or_d_c     = 1'b1;
                mem_write_c  = 1'b1;
                instr_done_c = mem_rdy;
            end
            ST_R_EX: begin
                alu_src_a_c = 1'b1;
                case (bus.func)
                    FN_SUB:  alu_cntrl_c = ALU_SUB;
                    FN_AND:  alu_cntrl_c = ALU_AND;
                    FN_OR:   alu_cntrl_c = ALU_OR;
                    FN_SLT:  alu_cntrl_c = ALU_SLT;
                    default: alu_cntrl_c = ALU_ADD;
                endcase
            end
            ST_R_WB: begin
                reg_dst_c    = 1'b1;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            ST_I_EX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_cntrl_c = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            ST_I_WB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a_c     = 1'b1;
                alu_cntrl_c     = ALU_SUB;
                pc_src_c        = 2'b01;
                pc_write_cond_c = 1'b1;
                instr_done_c    = 1'b1;
            end
            ST_JMP: begin
                pc_src_c     = 2'b10;
                pc_write_c   = 1'b1;
                instr_done_c = 1'b1;
            end
            // Link register takes the already-incremented PC as PC takes the target
            ST_JAL: begin
                pc_src_c     = 2'b10;
                pc_write_c   = 1'b1;
                reg_write_c  = 1'b1;
                jal_reg_c    = 1'b1;
                pc_to_reg_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            ST_JR: begin
                pc_src_c     = 2'b11;
                pc_write_c   = 1'b1;
                instr_done_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are held low for the whole reset interval, not just after the edge
    assign bus.mem_read   = mem_read_c  & ~rst;
    assign bus.mem_write  = mem_write_c & ~rst;
    assign bus.ir_write   = ir_write_c  & ~rst;
    assign bus.reg_write  = reg_write_c & ~rst;
    assign bus.pc_ld      = (pc_write_c | (pc_write_cond_c & bus.ZERO)) & ~rst;
    assign bus.i_or_d     = i_or_d_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.jal_reg    = jal_reg_c;
    assign bus.pc_to_reg  = pc_to_reg_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_cntrl  = alu_cntrl_c;
    assign bus.pc_src     = pc_src_c;
    assign bus.instr_done = instr_done_c;
    assign bus.illegal    = illegal_c;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: walks each instruction class
// through the FSM and compares against hand-derived state/control values.
module tb_multi_cycle_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_cycle_controller_if m ();
    multi_cycle_controller_if z ();

    multi_cycle_controller #(.MEM_HANDSHAKE(1)) u_dut (
        .clk(clk), .rst(rst), .bus(m.master)
    );
    multi_cycle_controller #(.MEM_HANDSHAKE(0)) u_dut_nowait (
        .clk(clk), .rst(rst), .bus(z.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] lw_st  [8] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4};
    logic       lw_rdy [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        m.opcode = op;
        m.func   = fn;
    endtask

    task automatic run_beq(input logic zf, input logic exp_ld);
        m.mem_ready = 1'b1;
        m.ZERO      = zf;
        set_ir(6'b000100, 6'b000000);
        #1;
        check("beq_if", 32'(m.state), 32'd0);
        tick;
        check("beq_id", 32'(m.state), 32'd1);
        check("beq_id_srcb", 32'(m.alu_src_b), 32'd3);
        tick;
        check("beq_state", 32'(m.state), 32'd10);
        check("beq_alu", 32'(m.alu_cntrl), 32'b110);
        check("beq_pc_src", 32'(m.pc_src), 32'b01);
        check("beq_pc_ld", 32'(m.pc_ld), 32'(exp_ld));
        check("beq_done", 32'(m.instr_done), 32'd1);
        tick;
        check("beq_back_if", 32'(m.state), 32'd0);
    endtask

    task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn);
        set_ir(op, fn);
        tick;
        check("ill_id", 32'(m.state), 32'd1);
        check("ill_flag", 32'(m.illegal), 32'd1);
        check("ill_done", 32'(m.instr_done), 32'd1);
        check("ill_reg_write", 32'(m.reg_write), 32'd0);
        check("ill_mem_write", 32'(m.mem_write), 32'd0);
        tick;
        check("ill_back_if", 32'(m.state), 32'd0);
        check("ill_pulse_end", 32'(m.illegal), 32'd0);
    endtask

    initial begin
        int  n_pcld;
        int  n_irw;
        logic found;
        rst = 1'b1;
        m.opcode = 6'b000000; m.func = 6'b100000; m.ZERO = 1'b0; m.mem_ready = 1'b1;
        z.opcode = 6'b000000; z.func = 6'b100000; z.ZERO = 1'b0; z.mem_ready = 1'b0;

        // Reset: strobes held low, then IF fetch controls once released
        #12;
        check("rst_state", 32'(m.state), 32'd0);
        check("rst_mem_read", 32'(m.mem_read), 32'd0);
        check("rst_pc_ld", 32'(m.pc_ld), 32'd0);
        rst = 1'b0;
        #1;
        check("if_mem_read", 32'(m.mem_read), 32'd1);
        check("if_i_or_d", 32'(m.i_or_d), 32'd0);
        check("if_srcb", 32'(m.alu_src_b), 32'b01);

        // sw into MEM_WR, then async reset mid-access
        set_ir(6'b101011, 6'b000000);
        tick;
        check("sw_id", 32'(m.state), 32'd1);
        tick;
        check("sw_addr", 32'(m.state), 32'd2);
        check("sw_addr_srca", 32'(m.alu_src_a), 32'd1);
        check("sw_addr_srcb", 32'(m.alu_src_b), 32'b10);
        m.mem_ready = 1'b0;
        tick;
        check("sw_wr_state", 32'(m.state), 32'd5);
        check("sw_mem_write", 32'(m.mem_write), 32'd1);
        check("sw_wait_done", 32'(m.instr_done), 32'd0);
        #3 rst = 1'b1;
        #1;
        check("arst_mem_write", 32'(m.mem_write), 32'd0);
        check("arst_state", 32'(m.state), 32'd0);
        #1 rst = 1'b0;
        tick;
        check("if_hold", 32'(m.state), 32'd0);

        // add with zero-wait memory
        set_ir(6'b000000, 6'b100000);
        m.mem_ready = 1'b1;
        #1;
        check("add_ir_write", 32'(m.ir_write), 32'd1);
        check("add_pc_ld", 32'(m.pc_ld), 32'd1);
        tick;
        check("add_id", 32'(m.state), 32'd1);
        tick;
        check("add_rex", 32'(m.state), 32'd6);
        check("add_alu", 32'(m.alu_cntrl), 32'b010);
        check("add_srca", 32'(m.alu_src_a), 32'd1);
        check("add_srcb", 32'(m.alu_src_b), 32'b00);
        tick;
        check("add_rwb", 32'(m.state), 32'd7);
        check("add_reg_dst", 32'(m.reg_dst), 32'd1);
        check("add_reg_write", 32'(m.reg_write), 32'd1);
        check("add_done", 32'(m.instr_done), 32'd1);
        tick;
        check("add_back_if", 32'(m.state), 32'd0);

        // sub in R_EX selects SUB
        set_ir(6'b000000, 6'b100010);
        tick; tick;
        check("sub_alu", 32'(m.alu_cntrl), 32'b110);
        tick; tick;

        // lw with 2 IF waits and 1 MEM_RD wait: 8 cycles
        set_ir(6'b100011, 6'b000000);
        n_pcld = 0;
        n_irw  = 0;
        for (int i = 0; i < 8; i++) begin
            m.mem_ready = lw_rdy[i];
            #1;
            check($sformatf("lw_state%0d", i), 32'(m.state), 32'(lw_st[i]));
            n_pcld += int'(m.pc_ld);
            n_irw  += int'(m.ir_write);
            if (i == 7) check("lw_wb_done", 32'(m.instr_done), 32'd1);
            tick;
        end
        check("lw_end_if", 32'(m.state), 32'd0);
        check("lw_pc_ld_cnt", 32'(n_pcld), 32'd1);
        check("lw_ir_write_cnt", 32'(n_irw), 32'd1);

        // beq not taken / taken
        run_beq(1'b0, 1'b0);
        run_beq(1'b1, 1'b1);
        m.ZERO = 1'b0;

        // jal and jr
        set_ir(6'b000011, 6'b000000);
        tick; tick;
        check("jal_state", 32'(m.state), 32'd12);
        check("jal_pc_ld", 32'(m.pc_ld), 32'd1);
        check("jal_pc_src", 32'(m.pc_src), 32'b10);
        check("jal_reg_write", 32'(m.reg_write), 32'd1);
        check("jal_jal_reg", 32'(m.jal_reg), 32'd1);
        check("jal_pc_to_reg", 32'(m.pc_to_reg), 32'd1);
        tick;
        set_ir(6'b000000, 6'b001000);
        tick; tick;
        check("jr_state", 32'(m.state), 32'd13);
        check("jr_pc_src", 32'(m.pc_src), 32'b11);
        check("jr_pc_ld", 32'(m.pc_ld), 32'd1);
        check("jr_reg_write", 32'(m.reg_write), 32'd0);
        tick;
        check("jr_back_if", 32'(m.state), 32'd0);

        // undecodable opcode and func
        run_illegal(6'b111111, 6'b000000);
        run_illegal(6'b000000, 6'b000111);

        // no-handshake instance: add completes in 4 cycles with mem_ready tied 0
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (z.state == 4'd0) found = 1'b1;
            else tick;
        end
        check("nw_find_if", 32'(found), 32'd1);
        tick;
        check("nw_id", 32'(z.state), 32'd1);
        tick;
        check("nw_rex", 32'(z.state), 32'd6);
        tick;
        check("nw_rwb", 32'(z.state), 32'd7);
        check("nw_done", 32'(z.instr_done), 32'd1);
        tick;
        check("nw_back_if", 32'(z.state), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
